// File: rtl/lif_sched_pkg.sv
// Shared types and helpers for the time-multiplexed LIF neuron scheduler.
package lif_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    COMMIT
  } sched_state_t;

  localparam int unsigned MEM_W = 8;

  // Clamp a carry-extended membrane sum to the 8-bit maximum.
  function automatic logic [MEM_W-1:0] sat8(input logic [MEM_W:0] sum);
    return sum[MEM_W] ? '1 : sum[MEM_W-1:0];
  endfunction

endpackage

// File: rtl/lif_update_core.sv
// Shared combinational LIF update: (membrane, current[, refractory]) -> next state.
// Refractory counter ports exist only when LIF_REFRACTORY_EN is defined.
module lif_update_core
  import lif_sched_pkg::*;
#(
`ifdef LIF_REFRACTORY_EN
  parameter int unsigned      REFRACT_TICKS = 2,
  parameter int unsigned      RC_W          = 2,
`endif
  parameter logic [MEM_W-1:0] THRESHOLD     = 8'd127
) (
`ifdef LIF_REFRACTORY_EN
  input  logic [RC_W-1:0]  i_rc,
  output logic [RC_W-1:0]  o_rc,
`endif
  input  logic [MEM_W-1:0] i_m,
  input  logic [MEM_W-1:0] i_cur,
  output logic [MEM_W-1:0] o_m,
  output logic             o_spike
);

  logic             w_fire;
  logic [MEM_W-1:0] w_leak;

  always_comb begin
    w_fire  = (i_m >= THRESHOLD);
    w_leak  = w_fire ? '0 : (i_m >> 1);
    o_m     = sat8({1'b0, i_cur} + {1'b0, w_leak});
    o_spike = w_fire;
`ifdef LIF_REFRACTORY_EN
    o_rc = i_rc;
    if (i_rc != '0) begin
      o_m     = '0;
      o_spike = 1'b0;
      o_rc    = i_rc - 1'b1;
    end else if (w_fire) begin
      o_rc = RC_W'(REFRACT_TICKS);
    end
`endif
  end

endmodule

// File: rtl/lif_tdm_scheduler.sv
// Sweeps a chain of LIF neurons through one shared update core, one neuron per clock.
// Optional per-neuron refractory hold: define LIF_REFRACTORY_EN.
module lif_tdm_scheduler
  import lif_sched_pkg::*;
#(
  parameter int unsigned      N_NEURONS     = 3,
  parameter logic [MEM_W-1:0] THRESHOLD     = 8'd127,
  parameter logic [MEM_W-1:0] SYN_WEIGHT    = 8'd128,
  parameter int unsigned      REFRACT_TICKS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick_i,
  input  logic [MEM_W-1:0]             current_i,
  input  logic [$clog2(N_NEURONS)-1:0] sel_i,
  output logic [MEM_W-1:0]             state_o,
  output logic [N_NEURONS-1:0]         spikes_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         overrun_o
);

  localparam int unsigned      IDX_W    = $clog2(N_NEURONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
  localparam logic [IDX_W:0]   N_CNT    = (IDX_W + 1)'(N_NEURONS);

  if (N_NEURONS < 2 || N_NEURONS > 16 || REFRACT_TICKS > 255) begin : g_param_check
    $error("lif_tdm_scheduler: parameter out of range");
  end

  sched_state_t           r_state, w_next;
  logic [IDX_W-1:0]       r_idx;
  logic [MEM_W-1:0]       r_cur;
  logic                   r_prev;
  logic [N_NEURONS-1:0]   r_acc;
  logic [MEM_W-1:0]       r_mem [N_NEURONS];
  logic [MEM_W-1:0]       r_state_o;
  logic [N_NEURONS-1:0]   r_spikes;
  logic                   r_busy, r_done, r_overrun;
  logic [MEM_W-1:0]       w_cur, w_m_next;
  logic                   w_spike;

`ifdef LIF_REFRACTORY_EN
  localparam int unsigned RC_W = $clog2(REFRACT_TICKS + 1);
  logic [RC_W-1:0] r_rc [N_NEURONS];
  logic [RC_W-1:0] w_rc_next;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (tick_i) w_next = SWEEP;
      SWEEP:   if (r_idx == LAST_IDX) w_next = COMMIT;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_cur = (r_idx == '0) ? r_cur : (r_prev ? SYN_WEIGHT : '0);

  lif_update_core #(
`ifdef LIF_REFRACTORY_EN
    .REFRACT_TICKS (REFRACT_TICKS),
    .RC_W          (RC_W),
`endif
    .THRESHOLD     (THRESHOLD)
  ) u_core (
`ifdef LIF_REFRACTORY_EN
    .i_rc    (r_rc[r_idx]),
    .o_rc    (w_rc_next),
`endif
    .i_m     (r_mem[r_idx]),
    .i_cur   (w_cur),
    .o_m     (w_m_next),
    .o_spike (w_spike)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_cur     <= '0;
      r_prev    <= 1'b0;
      r_acc     <= '0;
      r_state_o <= '0;
      r_spikes  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      for (int unsigned i = 0; i < N_NEURONS; i++) begin
        r_mem[i] <= '0;
`ifdef LIF_REFRACTORY_EN
        r_rc[i]  <= '0;
`endif
      end
    end else begin
      r_state   <= w_next;
      r_busy    <= (w_next != IDLE);
      r_done    <= (r_state == COMMIT);
      // Readout samples the array before this edge's sweep write lands.
      r_state_o <= ({1'b0, sel_i} < N_CNT) ? r_mem[sel_i] : '0;
      if (tick_i && r_state != IDLE) r_overrun <= 1'b1;
      case (r_state)
        IDLE: if (tick_i) begin
          r_cur  <= current_i;
          r_idx  <= '0;
          r_prev <= 1'b0;
        end
        SWEEP: begin
          r_mem[r_idx] <= w_m_next;
          r_acc[r_idx] <= w_spike;
          r_prev       <= w_spike;
`ifdef LIF_REFRACTORY_EN
          r_rc[r_idx]  <= w_rc_next;
`endif
          if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
        end
        COMMIT:  r_spikes <= r_acc;
        default: ;
      endcase
    end
  end

  assign state_o   = r_state_o;
  assign spikes_o  = r_spikes;
  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign overrun_o = r_overrun;

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Scoreboard bench for lif_tdm_scheduler: a reference LIF chain model predicts
// each sweep's spike vector and membranes; spikes are checked when done_o fires.
module tb_lif_tdm_scheduler;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick_i;
  logic [7:0]   current_i;
  logic [1:0]   sel_i;
  logic [7:0]   state_o;
  logic [N-1:0] spikes_o;
  logic         busy_o, done_o, overrun_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [N-1:0] sb_q[$];
  int mdl_m  [N];
  int mdl_rc [N];

  lif_tdm_scheduler #(
    .N_NEURONS     (N),
    .THRESHOLD     (8'd127),
    .SYN_WEIGHT    (8'd128),
    .REFRACT_TICKS (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_i    (tick_i),
    .current_i (current_i),
    .sel_i     (sel_i),
    .state_o   (state_o),
    .spikes_o  (spikes_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .overrun_o (overrun_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      mdl_m[k]  = 0;
      mdl_rc[k] = 0;
    end
  endfunction

  function automatic logic [N-1:0] model_sweep(input int cur0);
    logic [N-1:0] v;
    bit prev;
    bit s;
    int c;
    int nm;
    v = '0;
    prev = 1'b0;
    for (int k = 0; k < N; k++) begin
      c  = (k == 0) ? cur0 : (prev ? 128 : 0);
      s  = (mdl_m[k] >= 127);
      nm = c + (s ? 0 : mdl_m[k] / 2);
      if (nm > 255) nm = 255;
`ifdef LIF_REFRACTORY_EN
      if (mdl_rc[k] != 0) begin
        nm = 0;
        s  = 1'b0;
        mdl_rc[k] = mdl_rc[k] - 1;
      end else if (s) begin
        mdl_rc[k] = 2;
      end
`endif
      mdl_m[k] = nm;
      prev = s;
      v[k] = s;
    end
    return v;
  endfunction

  // Every completed sweep must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (!rst && done_o) begin
      if (sb_q.size() == 0) check("extra_done", done_o, 0);
      else check("spikes", spikes_o, sb_q.pop_front());
    end
  end

  task automatic tick(input logic [7:0] c);
    int lat;
    @(negedge clk);
    tick_i = 1'b1;
    current_i = c;
    sb_q.push_back(model_sweep(int'(c)));
    @(negedge clk);
    tick_i = 1'b0;
    current_i = 8'($urandom);
    check("busy_rise", busy_o, 1);
    lat = 0;
    while (!done_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("done_latency", lat, N + 1);
    check("busy_at_done", busy_o, 0);
    @(negedge clk);
    check("done_width", done_o, 0);
  endtask

  task automatic read_mem(input int k, input int exp, input string tag);
    @(negedge clk);
    sel_i = k[1:0];
    @(negedge clk);
    check(tag, state_o, exp);
  endtask

  task automatic read_all();
    for (int k = 0; k < N; k++) read_mem(k, mdl_m[k], $sformatf("mem%0d", k));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int lat;
    rst = 1'b1;
    tick_i = 1'b0;
    current_i = '0;
    sel_i = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_spikes", spikes_o, 0);
    check("rst_overrun", overrun_o, 0);
    read_all();
    read_mem(3, 0, "sel_oob_rst");

    tick(8'd200); read_all();
    check("chain1", spikes_o, 3'b000);
    tick(8'd0);   read_all();
    check("chain2", spikes_o, 3'b001);
    read_mem(1, 128, "chain2_m1");
    tick(8'd0);   read_all();
    check("chain3", spikes_o, 3'b010);
    read_mem(2, 128, "chain3_m2");
    tick(8'd0);   read_all();
    check("chain4", spikes_o, 3'b100);

    tick(8'd100); read_mem(0, 100, "decay0");
    tick(8'd0);   read_mem(0, 50,  "decay1");
    tick(8'd0);   read_mem(0, 25,  "decay2");
    tick(8'd0);   read_mem(0, 12,  "decay3");
    check("decay_spikes", spikes_o, 3'b000);

    tick(8'd200); read_all();
    tick(8'd255); read_all();
`ifndef LIF_REFRACTORY_EN
    read_mem(0, 255, "sat1_m0");
    check("sat1_spike", spikes_o[0], 1);
`endif
    tick(8'd255); read_all();
`ifndef LIF_REFRACTORY_EN
    read_mem(0, 255, "sat2_m0");
    check("sat2_spike", spikes_o[0], 1);
`endif
    read_mem(3, 0, "sel_oob");

    check("overrun_pre", overrun_o, 0);
    @(negedge clk);
    tick_i = 1'b1;
    current_i = 8'd50;
    sb_q.push_back(model_sweep(50));
    @(negedge clk);
    tick_i = 1'b0;
    @(negedge clk);
    tick_i = 1'b1;
    current_i = 8'd255;
    @(negedge clk);
    tick_i = 1'b0;
    current_i = 8'd0;
    lat = 0;
    while (!done_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("ovr_done_seen", done_o, 1);
    check("ovr_flag", overrun_o, 1);
    repeat (6) @(negedge clk);
    check("ovr_sticky", overrun_o, 1);
    read_all();

    @(negedge clk);
    tick_i = 1'b1;
    current_i = 8'd200;
    @(negedge clk);
    tick_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_done", done_o, 0);
    check("mid_rst_spikes", spikes_o, 0);
    check("mid_rst_overrun", overrun_o, 0);
    read_all();
    repeat (6) @(negedge clk);
    check("mid_rst_no_done", done_o, 0);

    tick(8'd130); read_all();
    tick(8'd0);   read_all();

    repeat (4) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
